pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter RST_PC, default 32'h0000_3000, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter FLUSH_KEEP_PC, default 1; 1 means flush preserves the PC field, 0 means flush clears it to 0.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port stall, input, 1 bit: hold the current contents.
REQ-008 The block SHALL have port flush, input, 1 bit: replace the contents with a bubble.
REQ-009 The block SHALL have port valid_in, input, 1 bit: the upstream stage holds a real instruction.
REQ-010 The block SHALL have port instr_in, input, 32 bits: the upstream instruction word.
REQ-011 The block SHALL have port rd_in, input, 5 bits: the upstream destination register number (0 means no write).
REQ-012 The block SHALL have port data_in, input, DATA_W bits: the upstream payload (ALU result, rt value, etc.).
REQ-013 The block SHALL have port pc_in, input, 32 bits: the upstream PC.
REQ-014 The block SHALL have outputs valid_out (1), instr_out (32), rd_out (5), data_out (DATA_W) and pc_out (32), giving the registered stage contents.
REQ-015 The block SHALL have output bubble_out, 1 bit: the current contents came from a flush.
REQ-016 The block SHALL have output stall_cnt, CNT_W bits: count of cycles a valid instruction was held.

Function
REQ-017 All outputs SHALL be driven directly from registers, with no combinational path from input to output.
REQ-018 The update priority at each rising clk edge SHALL be, highest first: reset, then flush, then stall, then load.
REQ-019 Load (stall=0, flush=0) SHALL capture all *_in fields into the matching *_out fields, set valid_out=valid_in and set bubble_out=0, for a latency of 1 cycle.
REQ-020 Stall (stall=1, flush=0) SHALL hold valid_out, instr_out, rd_out, data_out, pc_out and bubble_out unchanged.
REQ-021 Flush SHALL set valid_out=0, instr_out=0 (nop), rd_out=0, data_out=0 and bubble_out=1.
REQ-022 On flush, pc_out SHALL take pc_in if FLUSH_KEEP_PC=1, and 0 otherwise.
REQ-023 Flush asserted together with stall SHALL act as a flush, and the stall SHALL be ignored for that cycle.
REQ-024 A load with valid_in=0 SHALL capture the fields as presented, set valid_out=0 and set bubble_out=0.
REQ-025 rd_out SHALL be forced to 0 whenever valid_out is 0 after any update, so that an invalid stage never requests a register write.
REQ-026 stall_cnt SHALL increment by 1 on each edge where stall=1, flush=0, reset=0 and valid_out=1.
REQ-027 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap around.
REQ-028 stall_cnt SHALL be unaffected by flush and SHALL be cleared only by reset.
REQ-029 Stall cycles SHALL NOT be counted while the stage holds a bubble or an invalid instruction.
REQ-030 Consecutive stalls of any length SHALL hold the contents indefinitely, with no data loss.

Reset
REQ-031 While reset=1 at a rising edge, the block SHALL set valid_out=0, instr_out=0, rd_out=0, data_out=0, pc_out=RST_PC, bubble_out=0 and stall_cnt=0, regardless of stall and flush.
REQ-032 Reset asserted mid-stall or mid-flush SHALL take effect at the next edge; the first load after reset deasserts SHALL capture inputs normally.
REQ-033 Before the first rising edge with reset=1, output values SHALL be unspecified; the bench SHALL check outputs only after reset.

Verification
REQ-034 The bench SHALL cover basic load and reset: reset for 2 cycles, then a load of instr_in=32'h0043_2021, rd_in=4, data_in=32'h55, pc_in=32'h3004, valid_in=1; this SHALL produce exactly those outputs one cycle later, with bubble_out=0, and pc_out=32'h3000 during reset.
REQ-035 The bench SHALL cover stall hold: after a valid load, stall=1 for 3 cycles with the inputs changed each cycle; the outputs SHALL stay unchanged and stall_cnt SHALL read 3.
REQ-036 The bench SHALL cover flush with stall: flush=1, stall=1, pc_in=32'h3010; the response SHALL be valid_out=0, instr_out=0, rd_out=0, data_out=0, bubble_out=1, pc_out=32'h3010 (FLUSH_KEEP_PC=1), and pc_out=0 in a second instance with FLUSH_KEEP_PC=0.
REQ-037 The bench SHALL cover a stalled bubble: a flush followed by stall=1 for 4 cycles; bubble_out SHALL stay 1 and stall_cnt SHALL be unchanged.
REQ-038 The bench SHALL cover saturation: with CNT_W=3, a valid instruction stalled for 10 cycles SHALL give stall_cnt=7, and it SHALL stay at 7 while the stall continues.
REQ-039 The bench SHALL cover reset during a stall: reset=1 while stall=1 and valid_out=1; the next edge SHALL give all reset values and stall_cnt=0, and the first load after reset SHALL capture the inputs.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with stall/flush priority and a saturating stall counter
module pipe_stage_reg #(
   parameter int          DATA_W        = 32,
   parameter logic [31:0] RST_PC        = 32'h0000_3000,
   parameter bit          FLUSH_KEEP_PC = 1'b1,
   parameter int          CNT_W         = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [31:0]       instr_in,
   input  logic [4:0]        rd_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [31:0]       pc_in,
   output logic              valid_out,
   output logic [31:0]       instr_out,
   output logic [4:0]        rd_out,
   output logic [DATA_W-1:0] data_out,
   output logic [31:0]       pc_out,
   output logic              bubble_out,
   output logic [CNT_W-1:0]  stall_cnt
);
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out  <= 1'b0;
         instr_out  <= '0;
         rd_out     <= '0;
         data_out   <= '0;
         pc_out     <= RST_PC;
         bubble_out <= 1'b0;
      end else if (flush) begin
         valid_out  <= 1'b0;
         instr_out  <= '0;
         rd_out     <= '0;
         data_out   <= '0;
         pc_out     <= FLUSH_KEEP_PC ? pc_in : '0;
         bubble_out <= 1'b1;
      end else if (!stall) begin
         valid_out  <= valid_in;
         instr_out  <= instr_in;
         rd_out     <= valid_in ? rd_in : '0;
         data_out   <= data_in;
         pc_out     <= pc_in;
         bubble_out <= 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall && !flush && valid_out && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of three configurations against a rule-level model
module tb_pipe_stage_reg;
   logic clk = 1'b0;
   logic reset = 1'b0, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
   logic [31:0] instr_in = '0, data_in = '0, pc_in = '0;
   logic [4:0] rd_in = '0;
   logic va, vb, vc, ba, bb, bc;
   logic [31:0] ia, ib, ic, da, db, dc, pa, pb, pc;
   logic [4:0] ra, rb, rc;
   logic [15:0] ca, cb;
   logic [2:0] cc;
   int tests = 0, fails = 0;
   logic m_valid, m_bub;
   logic [31:0] m_instr, m_data, m_pc_keep, m_pc_clr;
   logic [4:0] m_rd;
   int raw_cnt;

   always #5 clk = ~clk;

   pipe_stage_reg dut_a (.clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .instr_in(instr_in), .rd_in(rd_in), .data_in(data_in), .pc_in(pc_in), .valid_out(va),
      .instr_out(ia), .rd_out(ra), .data_out(da), .pc_out(pa), .bubble_out(ba), .stall_cnt(ca));
   pipe_stage_reg #(.FLUSH_KEEP_PC(1'b0)) dut_b (.clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_in(valid_in), .instr_in(instr_in), .rd_in(rd_in), .data_in(data_in), .pc_in(pc_in),
      .valid_out(vb), .instr_out(ib), .rd_out(rb), .data_out(db), .pc_out(pb), .bubble_out(bb), .stall_cnt(cb));
   pipe_stage_reg #(.CNT_W(3)) dut_c (.clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_in(valid_in), .instr_in(instr_in), .rd_in(rd_in), .data_in(data_in), .pc_in(pc_in),
      .valid_out(vc), .instr_out(ic), .rd_out(rc), .data_out(dc), .pc_out(pc), .bubble_out(bc), .stall_cnt(cc));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int sat16, sat3;
      sat16 = raw_cnt > 65535 ? 65535 : raw_cnt;
      sat3 = raw_cnt > 7 ? 7 : raw_cnt;
      chk("valid_a", va, m_valid); chk("valid_b", vb, m_valid); chk("valid_c", vc, m_valid);
      chk("instr_a", ia, m_instr); chk("instr_b", ib, m_instr); chk("instr_c", ic, m_instr);
      chk("rd_a", ra, m_rd); chk("rd_b", rb, m_rd); chk("rd_c", rc, m_rd);
      chk("data_a", da, m_data); chk("data_b", db, m_data); chk("data_c", dc, m_data);
      chk("pc_a", pa, m_pc_keep); chk("pc_b", pb, m_pc_clr); chk("pc_c", pc, m_pc_keep);
      chk("bubble_a", ba, m_bub); chk("bubble_b", bb, m_bub); chk("bubble_c", bc, m_bub);
      chk("cnt_a", ca, sat16); chk("cnt_b", cb, sat16); chk("cnt_c", cc, sat3);
   endtask

   // An invalid instruction never names a destination, a bubble is a cleared invalid slot,
   // and the stall counter is just a total of held valid cycles clipped to the counter range.
   task automatic cycle(input logic r, s, f, v, input logic [31:0] ins, input logic [4:0] rd,
                        input logic [31:0] d, input logic [31:0] p);
      reset = r; stall = s; flush = f; valid_in = v;
      instr_in = ins; rd_in = rd; data_in = d; pc_in = p;
      @(posedge clk);
      if (r) begin
         {m_valid, m_instr, m_rd, m_data, m_bub} = '0;
         m_pc_keep = 32'h3000; m_pc_clr = 32'h3000; raw_cnt = 0;
      end else if (f) begin
         {m_valid, m_instr, m_rd, m_data} = '0;
         m_bub = 1'b1; m_pc_keep = p; m_pc_clr = 32'h0;
      end else if (s) begin
         if (m_valid) raw_cnt++;
      end else begin
         m_valid = v; m_instr = ins; m_rd = v ? rd : 5'd0; m_data = d;
         m_pc_keep = p; m_pc_clr = p; m_bub = 1'b0;
      end
      #1 check_all();
   endtask

   task automatic rnd(input logic r, s, f, v);
      cycle(r, s, f, v, $urandom, 5'($urandom), $urandom, $urandom);
   endtask

   initial begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 1, 1, 32'hdead_beef, 5'd9, 32'h1, 32'h4);
      chk("reset_pc", pa, 32'h3000);
      cycle(0, 0, 0, 1, 32'h0043_2021, 5'd4, 32'h55, 32'h3004);
      chk("load_instr", ia, 32'h0043_2021);
      chk("load_pc", pa, 32'h3004);
      for (int i = 0; i < 3; i++) rnd(0, 1, 0, $urandom);
      chk("stall3_cnt", ca, 16'd3);
      chk("stall3_rd", ra, 5'd4);
      cycle(0, 1, 1, 1, $urandom, 5'd7, $urandom, 32'h3010);
      chk("flush_pc_keep", pa, 32'h3010);
      chk("flush_pc_clr", pb, 32'h0);
      for (int i = 0; i < 4; i++) rnd(0, 1, 0, 1);
      chk("bubble_cnt", ca, 16'd3);
      rnd(0, 0, 0, 0);
      rnd(0, 1, 0, 1);
      rnd(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) rnd(0, 1, 0, $urandom);
      chk("sat_cnt", cc, 3'd7);
      for (int i = 0; i < 3; i++) rnd(0, 1, 0, $urandom);
      chk("sat_hold", cc, 3'd7);
      rnd(1, 1, 0, 1);
      chk("reset_stall_cnt", ca, 16'd0);
      cycle(0, 0, 0, 1, 32'h1234_5678, 5'd31, 32'hcafe, 32'h3008);
      chk("post_reset_load", ia, 32'h1234_5678);
      for (int i = 0; i < 300; i++)
         rnd($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
